// File: rtl/vc4000_cart_loader.sv
// Streams an HPS cartridge download into RAM one byte at a time, then derives image size, mirror mask and loaded flag.
// One cycle to register each byte; ioctl_wait holds the HPS off until mem_ack, and bytes arriving meanwhile are dropped and flagged.
module vc4000_cart_loader #(
    parameter logic [7:0] CART_INDEX = 8'd1,
    parameter int         MAX_SIZE   = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic [13:0] cart_size,
    output logic [12:0] cart_mask,
    output logic        loaded,
    output logic        overflow,
    output logic        cpu_hold
);

    localparam logic [24:0] MAX_ADDR = 25'(MAX_SIZE);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_t;

    state_t      state_q, state_d;
    logic        end_q, end_d;
    logic        wait_d, we_d, loaded_d, overflow_d;
    logic [12:0] addr_d, mask_d;
    logic [7:0]  din_d;
    logic [13:0] size_d, next_size;

    // Smear the top set bit of (size-1) downward to get the smallest 2^n-1 cover.
    function automatic logic [12:0] size_to_mask(input logic [13:0] size);
        logic [13:0] v;
        logic [12:0] m;
        v = (size == 14'd0) ? 14'd0 : size - 14'd1;
        m = '0;
        m[12] = v[13] | v[12];
        for (int i = 11; i >= 0; i--) begin
            m[i] = m[i+1] | v[i];
        end
        return m;
    endfunction

    assign next_size = {1'b0, mem_addr} + 14'd1;
    assign cpu_hold  = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        end_d      = end_q;
        wait_d     = ioctl_wait;
        we_d       = mem_we;
        addr_d     = mem_addr;
        din_d      = mem_din;
        size_d     = cart_size;
        mask_d     = cart_mask;
        loaded_d   = loaded;
        overflow_d = overflow;
        case (state_q)
            IDLE: begin
                if (ioctl_download && ioctl_index == CART_INDEX) begin
                    state_d    = LOAD;
                    end_d      = 1'b0;
                    size_d     = '0;
                    mask_d     = '0;
                    loaded_d   = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            LOAD: begin
                if (!ioctl_download) begin
                    state_d = FINISH;
                end else if (ioctl_wr) begin
                    if (ioctl_addr < MAX_ADDR) begin
                        addr_d  = ioctl_addr[12:0];
                        din_d   = ioctl_dout;
                        we_d    = 1'b1;
                        wait_d  = 1'b1;
                        state_d = WRITE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (ioctl_wr) overflow_d = 1'b1;
                // Remember an early end of session so a later re-assert cannot resurrect it.
                if (!ioctl_download) end_d = 1'b1;
                if (mem_ack) begin
                    we_d   = 1'b0;
                    wait_d = 1'b0;
                    if (next_size > cart_size) size_d = next_size;
                    state_d = (end_q || !ioctl_download) ? FINISH : LOAD;
                end
            end
            FINISH: begin
                mask_d   = size_to_mask(cart_size);
                loaded_d = (cart_size != 14'd0);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            end_q      <= 1'b0;
            ioctl_wait <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            cart_size  <= '0;
            cart_mask  <= '0;
            loaded     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            end_q      <= end_d;
            ioctl_wait <= wait_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_din    <= din_d;
            cart_size  <= size_d;
            cart_mask  <= mask_d;
            loaded     <= loaded_d;
            overflow   <= overflow_d;
        end
    end

endmodule

// File: doc/vc4000_cart_loader.md
VC4000_CART_LOADER -- requirements
Module: vc4000_cart_loader

Interface
REQ-001 The block SHALL have parameter CART_INDEX, default 8'd1, meaning the ioctl_index value that selects a cartridge download.
REQ-002 The block SHALL have parameter MAX_SIZE, default 8192, meaning the cartridge RAM capacity in bytes (power of two, at most 8192).
REQ-003 clk  in  1  core system clock; every register is clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  high while the HPS download session is active.
REQ-006 ioctl_index  in  8  file slot of the current download.
REQ-007 ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 ioctl_addr  in  25  byte offset of ioctl_dout.
REQ-009 ioctl_dout  in  8  download data byte.
REQ-010 ioctl_wait  out  1  back-pressure to the HPS; high while a byte is pending.
REQ-011 mem_addr  out  13  cartridge RAM write address.
REQ-012 mem_din  out  8  cartridge RAM write data.
REQ-013 mem_we  out  1  write request; held high until mem_ack.
REQ-014 mem_ack  in  1  RAM has accepted the write this cycle.
REQ-015 cart_size  out  14  bytes loaded (highest accepted address + 1).
REQ-016 cart_mask  out  13  address mirror mask for the cartridge decoder.
REQ-017 loaded  out  1  a non-empty cartridge image is valid.
REQ-018 overflow  out  1  sticky flag; a byte was dropped during the current session.
REQ-019 cpu_hold  out  1  holds the 2650 CPU in reset during a load.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, WRITE and FINISH.
REQ-021 In IDLE, ioctl_download=1 with ioctl_index==CART_INDEX SHALL, on the next cycle, enter LOAD and clear cart_size, cart_mask, loaded and overflow; cpu_hold SHALL be 1 in every state except IDLE.
REQ-022 A download with any other index SHALL be ignored, and the block SHALL stay in IDLE.
REQ-023 In LOAD, ioctl_wr=1 with ioctl_addr<MAX_SIZE SHALL register the address and data into mem_addr and mem_din, set mem_we=1 and ioctl_wait=1 on the next cycle, and enter WRITE.
REQ-024 In LOAD, ioctl_wr=1 with ioctl_addr>=MAX_SIZE SHALL drop the byte, set overflow=1, leave ioctl_wait at 0, and stay in LOAD.
REQ-025 In WRITE, mem_we SHALL stay 1 with mem_addr and mem_din stable until mem_ack=1.
REQ-026 In the cycle after mem_ack, the block SHALL set mem_we=0 and ioctl_wait=0, update cart_size to max(cart_size, mem_addr+1), and return to LOAD.
REQ-027 An ioctl_wr arriving while in WRITE SHALL be dropped and SHALL set overflow=1.
REQ-028 Deassertion of ioctl_download in LOAD SHALL enter FINISH.
REQ-029 Deassertion of ioctl_download in WRITE SHALL let the pending write complete, and then the block SHALL enter FINISH instead of LOAD.
REQ-030 FINISH SHALL last exactly one cycle.
REQ-031 In FINISH, cart_mask SHALL be set to (2^n)-1 for the smallest n with 2^n>=cart_size; cart_size of 0 or 1 SHALL give mask 0.
REQ-032 In FINISH, loaded SHALL be set to (cart_size!=0).
REQ-033 After FINISH the block SHALL return to IDLE, releasing cpu_hold on the cycle after FINISH.
REQ-034 A new matching download SHALL always restart from REQ-021; bytes written by earlier sessions are not cleared in RAM.
REQ-035 Out-of-order addresses SHALL be accepted; cart_size SHALL track the maximum address + 1, never a byte count.
REQ-036 The ioctl_addr comparison SHALL use all 25 bits, so addresses at or above 2^13 can never alias into RAM.

Reset
REQ-037 While reset=1, on each clock the block SHALL force state=IDLE, ioctl_wait=0, mem_we=0, mem_addr=0, mem_din=0, cart_size=0, cart_mask=0, loaded=0, overflow=0 and cpu_hold=0.
REQ-038 Reset asserted mid-WRITE SHALL abort the write immediately: mem_we=0 on the next edge, and no cart_size update.
REQ-039 After reset deasserts with ioctl_download still high and a matching index, the block SHALL start a new session per REQ-021.

Verification
REQ-040 Load of 2048 sequential bytes with mem_ack one cycle after mem_we -> 2048 writes with matching data; at end cart_size=2048, cart_mask=0x7FF, loaded=1, overflow=0.
REQ-041 mem_ack delayed 5 cycles -> ioctl_wait high for 6 cycles per byte; mem_addr and mem_din stable throughout; no byte lost.
REQ-042 Download of 9000 bytes -> bytes 0..8191 written, bytes 8192..8999 dropped; cart_size=8192, cart_mask=0x1FFF, overflow=1.
REQ-043 Download with ioctl_index=0 -> no mem_we, cpu_hold=0, all outputs unchanged.
REQ-044 ioctl_download falls in the same cycle a write is pending -> the write completes, then FINISH; cart_size includes that byte; a 1500-byte image gives cart_mask=0x7FF.
REQ-045 reset pulsed while mem_we=1 at byte 100 -> mem_we=0 the next cycle and all outputs at reset values; a subsequent 16-byte load gives cart_size=16, cart_mask=0xF, loaded=1.
